// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream adapter.
package fifo_stream_pkg;
    localparam int BUF_DEPTH = 2;
    typedef logic [1:0] occ_t;
    typedef logic [0:0] idx_t;
endpackage

// File: rtl/fifo_stream_buf.sv
// Two-entry output buffer with head/tail indices and occupancy count.
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output occ_t             o_occ,
    output logic [WIDTH-1:0] o_head_data
);
    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    idx_t             r_head;
    idx_t             r_tail;
    occ_t             r_occ;

    // Index and occupancy tracking; clear discards all buffered entries.
    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_reset && !i_clear) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_mem[r_head];
endmodule

// File: rtl/fifo_stream_adapter.sv
// Converts a registered-read FIFO port into a valid/ready stream master.
// Optional counters enabled by FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    output logic             fifo_read_en,
    input  logic [WIDTH-1:0] fifo_read_data,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [31:0]      stall_count
`endif
);
    logic r_inflight;
    occ_t w_occ;
    logic w_pop;
    occ_t w_credit;

    fifo_stream_buf #(.WIDTH(WIDTH)) u_buf (
        .clk         (clk),
        .i_reset     (reset),
        .i_clear     (flush),
        .i_push      (r_inflight),
        .i_push_data (fifo_read_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head_data (m_data)
    );

    assign m_valid = !reset && (w_occ != 2'd0);
    assign w_pop   = m_valid && m_ready;
    // Slots committed after this cycle; pop implies occ>=1 so no underflow.
    assign w_credit = w_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    // Issue a FIFO read only when a buffer slot is guaranteed for the returning word.
    always_comb begin
        fifo_read_en = 1'b0;
        if (!reset && !flush && !fifo_empty && (w_credit < 2'd2)) begin
            fifo_read_en = 1'b1;
        end else begin
            fifo_read_en = 1'b0;
        end
    end

    // Track the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_read_en;
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] r_beat_count;
    logic [31:0] r_stall_count;

    // Handshake and back-pressure counters; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count  <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_pop) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            if (m_valid && !m_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign beat_count  = r_beat_count;
    assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Randomized and directed bench for fifo_stream_adapter with a queue-based reference.
module tb_fifo_stream_adapter;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       fifo_read_en;
    logic [7:0] fifo_read_data;
    logic       fifo_empty;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] beat_count;
    logic [31:0] stall_count;
`endif

    fifo_stream_adapter #(.WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .fifo_empty     (fifo_empty),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .beat_count     (beat_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    logic [7:0] delivered[$];
    int         pop_cyc[$];
    int         n_reads = 0;
    int         first_read_cyc = -1;
    int         first_valid_cyc = -1;
    int         m_beats = 0;
    int         m_stalls = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the FIFO model.
    task automatic step(input logic rst, input logic rdy, input logic fl);
        logic       exp_valid;
        logic       exp_ren;
        logic       rd;
        logic [7:0] w;
        int         held;
        reset = rst;
        m_ready = rdy;
        flush = fl;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        exp_valid = !rst && (exp_data.size() > 0) && (exp_cyc[0] + 2 <= cyc);
        held = exp_data.size() - ((exp_valid && rdy) ? 1 : 0);
        exp_ren = !rst && !fl && (fifo_q.size() > 0) && (held < 2);
        check("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
        check("fifo_read_en", {31'd0, fifo_read_en}, {31'd0, exp_ren});
        if (exp_valid) begin
            check("m_data", {24'd0, m_data}, {24'd0, exp_data[0]});
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_valid && rdy) begin
            delivered.push_back(exp_data[0]);
            pop_cyc.push_back(cyc);
            void'(exp_data.pop_front());
            void'(exp_cyc.pop_front());
            m_beats++;
        end
        if (exp_valid && !rdy) m_stalls++;
        rd = fifo_read_en && !fifo_empty;
        w = 8'd0;
        if (rd) begin
            w = fifo_q.pop_front();
            exp_data.push_back(w);
            exp_cyc.push_back(cyc);
            n_reads++;
            if (first_read_cyc < 0) first_read_cyc = cyc;
        end
        if (fl) begin
            exp_data.delete();
            exp_cyc.delete();
        end
        if (rst) begin
            exp_data.delete();
            exp_cyc.delete();
            fifo_q.delete();
            m_beats = 0;
            m_stalls = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rd) fifo_read_data = w;
    endtask

    task automatic clear_marks();
        delivered.delete();
        pop_cyc.delete();
        n_reads = 0;
        first_read_cyc = -1;
        first_valid_cyc = -1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_read_data = 8'd0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Three words, sink always ready.
        clear_marks();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        check("t1_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            check("t1_w0", {24'd0, delivered[0]}, 32'h11);
            check("t1_w1", {24'd0, delivered[1]}, 32'h22);
            check("t1_w2", {24'd0, delivered[2]}, 32'h33);
            check("t1_back_to_back", pop_cyc[2] - pop_cyc[0], 2);
        end
        check("t1_latency", first_valid_cyc - first_read_cyc, 2);

        // Back-pressure: only two reads may be outstanding.
        clear_marks();
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'h50 + 8'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        check("t2_reads_stalled", n_reads, 2);
        check("t2_held_valid", {31'd0, m_valid}, 32'd1);
        check("t2_held_data", {24'd0, m_data}, 32'h50);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        check("t2_drained", delivered.size(), 5);
        if (delivered.size() == 5) check("t2_last", {24'd0, delivered[4]}, 32'h54);

        // Toggling ready over eight words.
        clear_marks();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 24; i++) step(1'b0, logic'(i % 2 == 0), 1'b0);
        check("t3_count", delivered.size(), 8);
        for (int i = 0; i < delivered.size(); i++) check("t3_order", {24'd0, delivered[i]}, 32'hA0 + i);

        // Flush with one word buffered and one in flight.
        clear_marks();
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hC0 + 8'(i));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("t4_valid_after_flush", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        check("t4_count", delivered.size(), 3);
        if (delivered.size() > 0) check("t4_next_word", {24'd0, delivered[0]}, 32'hC2);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 12) fifo_q.push_back(8'($urandom));
            step(1'b0, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 39) == 0));
        end

        // Reset mid-stream.
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h70 + 8'(i));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("t5_valid_in_reset", {31'd0, m_valid}, 32'd0);
        check("t5_ren_in_reset", {31'd0, fifo_read_en}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("t5_valid_after_reset", {31'd0, m_valid}, 32'd0);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        check("t5_beats_cleared", beat_count, 32'd0);
        check("t5_stalls_cleared", stall_count, 32'd0);
`endif

        // Ten handshakes and four stall cycles.
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0);
        check("t6_model_beats", m_beats, 10);
        check("t6_model_stalls", m_stalls, 4);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        check("t6_beat_count", beat_count, 32'd10);
        check("t6_stall_count", stall_count, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
